// File: rtl/ccu_req_arbiter_pkg.sv
// Shared types for the CCU request arbiter: FSM states, request kind, atop bit position.
package ccu_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_AR,
    ISSUE_AW,
    WAIT_B,
    WAIT_R
  } state_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_kind_e;

  localparam int unsigned ATOP_R_BIT = 5;

endpackage

// File: rtl/ccu_req_arbiter_if.sv
// Master-side AR/AW request bundle plus the single CCU-side channel and completion strobes.
interface ccu_req_arbiter_if #(
  parameter int unsigned NoMstPorts = 4,
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned IdWidth    = 4
);
  localparam int unsigned IdxW   = $clog2(NoMstPorts);
  localparam int unsigned OutIdW = IdWidth + IdxW;

  logic [NoMstPorts-1:0]           mst_ar_valid_i;
  logic [NoMstPorts-1:0]           mst_ar_ready_o;
  logic [NoMstPorts*AddrWidth-1:0] mst_ar_addr_i;
  logic [NoMstPorts*IdWidth-1:0]   mst_ar_id_i;
  logic [NoMstPorts*4-1:0]         mst_ar_snoop_i;
  logic [NoMstPorts-1:0]           mst_aw_valid_i;
  logic [NoMstPorts-1:0]           mst_aw_ready_o;
  logic [NoMstPorts*AddrWidth-1:0] mst_aw_addr_i;
  logic [NoMstPorts*IdWidth-1:0]   mst_aw_id_i;
  logic [NoMstPorts*6-1:0]         mst_aw_atop_i;

  logic                            ccu_ar_valid_o;
  logic                            ccu_ar_ready_i;
  logic [AddrWidth-1:0]            ccu_ar_addr_o;
  logic [OutIdW-1:0]               ccu_ar_id_o;
  logic [3:0]                      ccu_ar_snoop_o;
  logic                            ccu_aw_valid_o;
  logic                            ccu_aw_ready_i;
  logic [AddrWidth-1:0]            ccu_aw_addr_o;
  logic [OutIdW-1:0]               ccu_aw_id_o;
  logic [5:0]                      ccu_aw_atop_o;
  logic                            ccu_r_last_hs_i;
  logic                            ccu_b_hs_i;

  modport slave (
    input  mst_ar_valid_i, mst_ar_addr_i, mst_ar_id_i, mst_ar_snoop_i,
    input  mst_aw_valid_i, mst_aw_addr_i, mst_aw_id_i, mst_aw_atop_i,
    output mst_ar_ready_o, mst_aw_ready_o,
    output ccu_ar_valid_o, ccu_ar_addr_o, ccu_ar_id_o, ccu_ar_snoop_o,
    output ccu_aw_valid_o, ccu_aw_addr_o, ccu_aw_id_o, ccu_aw_atop_o,
    input  ccu_ar_ready_i, ccu_aw_ready_i, ccu_r_last_hs_i, ccu_b_hs_i
  );

  modport master (
    output mst_ar_valid_i, mst_ar_addr_i, mst_ar_id_i, mst_ar_snoop_i,
    output mst_aw_valid_i, mst_aw_addr_i, mst_aw_id_i, mst_aw_atop_i,
    input  mst_ar_ready_o, mst_aw_ready_o,
    input  ccu_ar_valid_o, ccu_ar_addr_o, ccu_ar_id_o, ccu_ar_snoop_o,
    input  ccu_aw_valid_o, ccu_aw_addr_o, ccu_aw_id_o, ccu_aw_atop_o,
    output ccu_ar_ready_i, ccu_aw_ready_i, ccu_r_last_hs_i, ccu_b_hs_i
  );

endinterface

// File: rtl/ccu_req_arbiter_rr_arb_tree_lite.sv
// N-request round-robin picker; search starts at the pointer, winner+1 becomes the new pointer.
module rr_arb_tree_lite #(
  parameter  int unsigned N    = 8,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] ptr_d;
  logic [IdxW-1:0] cand;
  logic [IdxW-1:0] win;
  logic            found;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % N);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign valid_o = en_i & found;
  assign idx_o   = win;
  assign gnt_o   = valid_o ? (N'(1) << win) : '0;
  assign ptr_d   = (win == IdxW'(N - 1)) ? '0 : win + IdxW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (valid_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ccu_req_arbiter.sv
// Round-robin gate that lets one AR/AW transaction at a time into the CCU FSM.
// Optional watchdog on WAIT_R/WAIT_B enabled by defining CCU_ARB_TIMEOUT_EN.
module ccu_req_arbiter
  import ccu_arb_pkg::*;
#(
  parameter  int unsigned NoMstPorts    = 4,
  parameter  int unsigned AddrWidth     = 64,
  parameter  int unsigned IdWidth       = 4,
  parameter  int unsigned TimeoutCycles = 1024,
  localparam int unsigned IdxW          = $clog2(NoMstPorts),
  localparam int unsigned OutIdW        = IdWidth + IdxW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ccu_req_arbiter_if.slave bus,
  output logic             busy_o,
  output logic [IdxW-1:0]  owner_o,
  output logic             timeout_o
);

  localparam int unsigned NReq = 2 * NoMstPorts;
  localparam int unsigned ReqW = $clog2(NReq);

  logic [NReq-1:0]      req;
  logic [NReq-1:0]      gnt;
  logic                 gnt_valid;
  logic [ReqW-1:0]      gnt_idx;
  logic [IdxW-1:0]      gnt_mst;
  req_kind_e            gnt_kind;
  logic                 arb_en;
  state_e               state_q;
  state_e               state_d;

  logic [AddrWidth-1:0] ar_addr  [NoMstPorts];
  logic [IdWidth-1:0]   ar_id    [NoMstPorts];
  logic [3:0]           ar_snoop [NoMstPorts];
  logic [AddrWidth-1:0] aw_addr  [NoMstPorts];
  logic [IdWidth-1:0]   aw_id    [NoMstPorts];
  logic [5:0]           aw_atop  [NoMstPorts];

  logic [AddrWidth-1:0] addr_q;
  logic [OutIdW-1:0]    id_q;
  logic [3:0]           snoop_q;
  logic [5:0]           atop_q;
  logic [IdxW-1:0]      owner_q;

  // Requester order m0.AR, m0.AW, m1.AR, ...: bit 0 of the winner is the kind.
  for (genvar m = 0; m < NoMstPorts; m++) begin : g_port
    assign req[2*m]            = bus.mst_ar_valid_i[m];
    assign req[2*m+1]          = bus.mst_aw_valid_i[m];
    assign bus.mst_ar_ready_o[m] = gnt[2*m];
    assign bus.mst_aw_ready_o[m] = gnt[2*m+1];
    assign ar_addr[m]  = bus.mst_ar_addr_i[m*AddrWidth +: AddrWidth];
    assign ar_id[m]    = bus.mst_ar_id_i[m*IdWidth +: IdWidth];
    assign ar_snoop[m] = bus.mst_ar_snoop_i[m*4 +: 4];
    assign aw_addr[m]  = bus.mst_aw_addr_i[m*AddrWidth +: AddrWidth];
    assign aw_id[m]    = bus.mst_aw_id_i[m*IdWidth +: IdWidth];
    assign aw_atop[m]  = bus.mst_aw_atop_i[m*6 +: 6];
  end

  // Gated by reset so no ready pulse leaks out while the block is held in reset.
  assign arb_en = (state_q == IDLE) && !rst_i;

  rr_arb_tree_lite #(
    .N (NReq)
  ) u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (arb_en),
    .req_i   (req),
    .gnt_o   (gnt),
    .valid_o (gnt_valid),
    .idx_o   (gnt_idx)
  );

  assign gnt_mst  = gnt_idx[ReqW-1:1];
  assign gnt_kind = req_kind_e'(gnt_idx[0]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      id_q    <= '0;
      snoop_q <= '0;
      atop_q  <= '0;
      owner_q <= '0;
    end else if (gnt_valid) begin
      owner_q <= gnt_mst;
      if (gnt_kind == WRITE) begin
        addr_q  <= aw_addr[gnt_mst];
        id_q    <= {gnt_mst, aw_id[gnt_mst]};
        snoop_q <= '0;
        atop_q  <= aw_atop[gnt_mst];
      end else begin
        addr_q  <= ar_addr[gnt_mst];
        id_q    <= {gnt_mst, ar_id[gnt_mst]};
        snoop_q <= ar_snoop[gnt_mst];
        atop_q  <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    bus.ccu_ar_valid_o = 1'b0;
    bus.ccu_aw_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) state_d = (gnt_kind == WRITE) ? ISSUE_AW : ISSUE_AR;
      end
      ISSUE_AR: begin
        bus.ccu_ar_valid_o = 1'b1;
        if (bus.ccu_ar_ready_i) state_d = WAIT_R;
      end
      ISSUE_AW: begin
        bus.ccu_aw_valid_o = 1'b1;
        if (bus.ccu_aw_ready_i) state_d = WAIT_B;
      end
      WAIT_B: begin
        if (bus.ccu_b_hs_i) state_d = atop_q[ATOP_R_BIT] ? WAIT_R : IDLE;
      end
      WAIT_R: begin
        if (bus.ccu_r_last_hs_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ccu_ar_addr_o  = addr_q;
  assign bus.ccu_ar_id_o    = id_q;
  assign bus.ccu_ar_snoop_o = snoop_q;
  assign bus.ccu_aw_addr_o  = addr_q;
  assign bus.ccu_aw_id_o    = id_q;
  assign bus.ccu_aw_atop_o  = atop_q;
  assign busy_o             = (state_q != IDLE);
  assign owner_o            = owner_q;

`ifdef CCU_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles) + 1;

  logic [CntW-1:0] cnt_q;
  logic            to_q;
  logic            waiting;
  logic            hit;

  assign waiting = (state_q == WAIT_R) || (state_q == WAIT_B);
  assign hit     = waiting && (cnt_q == CntW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if (state_d != state_q) cnt_q <= '0;
      else if (waiting && !hit) cnt_q <= cnt_q + CntW'(1);
      if (hit) to_q <= 1'b1;
    end
  end

  // The limit cycle itself already reports, the sticky bit covers the rest.
  assign timeout_o = to_q | hit;
`else
  // TimeoutCycles is referenced only to keep the parameter list uniform across builds.
  assign timeout_o = 1'b0 & (TimeoutCycles == 0);
`endif

endmodule

// File: tb/tb_ccu_req_arbiter.sv
// Directed bench for ccu_req_arbiter: reset, round-robin, ID prefix, backpressure, atomics, watchdog.
`timescale 1ns/1ps
module tb_ccu_req_arbiter;

  localparam int unsigned NoMstPorts = 4;
  localparam int unsigned AddrWidth  = 64;
  localparam int unsigned IdWidth    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [1:0] owner;
  logic       timeout;
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  ccu_req_arbiter_if #(.NoMstPorts(NoMstPorts), .AddrWidth(AddrWidth), .IdWidth(IdWidth)) bus ();

  ccu_req_arbiter #(
    .NoMstPorts    (NoMstPorts),
    .AddrWidth     (AddrWidth),
    .IdWidth       (IdWidth),
    .TimeoutCycles (8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .busy_o    (busy),
    .owner_o   (owner),
    .timeout_o (timeout)
  );

  task automatic clear_inputs();
    bus.mst_ar_valid_i = '0; bus.mst_ar_addr_i = '0; bus.mst_ar_id_i = '0; bus.mst_ar_snoop_i = '0;
    bus.mst_aw_valid_i = '0; bus.mst_aw_addr_i = '0; bus.mst_aw_id_i = '0; bus.mst_aw_atop_i = '0;
    bus.ccu_ar_ready_i = 1'b0; bus.ccu_aw_ready_i = 1'b0;
    bus.ccu_r_last_hs_i = 1'b0; bus.ccu_b_hs_i = 1'b0;
  endtask

  task automatic set_ar(input int m, input logic [63:0] a, input logic [3:0] id, input logic [3:0] sn);
    bus.mst_ar_valid_i[m] = 1'b1;
    bus.mst_ar_addr_i[m*AddrWidth +: AddrWidth] = a;
    bus.mst_ar_id_i[m*IdWidth +: IdWidth] = id;
    bus.mst_ar_snoop_i[m*4 +: 4] = sn;
  endtask

  task automatic set_aw(input int m, input logic [63:0] a, input logic [3:0] id, input logic [5:0] at);
    bus.mst_aw_valid_i[m] = 1'b1;
    bus.mst_aw_addr_i[m*AddrWidth +: AddrWidth] = a;
    bus.mst_aw_id_i[m*IdWidth +: IdWidth] = id;
    bus.mst_aw_atop_i[m*6 +: 6] = at;
  endtask

  // Completes whatever is in flight, then leaves everything idle at a negedge.
  task automatic drain();
    bus.mst_ar_valid_i = '0; bus.mst_aw_valid_i = '0;
    bus.ccu_ar_ready_i = 1'b1; bus.ccu_aw_ready_i = 1'b1;
    bus.ccu_r_last_hs_i = 1'b1; bus.ccu_b_hs_i = 1'b1;
    repeat (4) @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.mst_ar_valid_i[1] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy, bus.ccu_ar_valid_o, bus.ccu_aw_valid_o, timeout, owner} !== 6'b0) begin
      errors++; $display("FAIL reset_status got=%b exp=0", {busy, bus.ccu_ar_valid_o, bus.ccu_aw_valid_o, timeout, owner});
    end
    checks++;
    if ({bus.ccu_ar_addr_o, bus.ccu_ar_id_o, bus.ccu_ar_snoop_o, bus.ccu_aw_atop_o} !== '0) begin
      errors++; $display("FAIL reset_payload got addr=%h id=%h exp=0", bus.ccu_ar_addr_o, bus.ccu_ar_id_o);
    end
    checks++;
    if (bus.mst_ar_ready_o !== 4'b0000) begin
      errors++; $display("FAIL reset_ready got=%b exp=0000", bus.mst_ar_ready_o);
    end
    bus.mst_ar_valid_i = '0;
    rst = 1'b0;
    @(negedge clk);
    set_ar(0, 64'h100, 4'h1, 4'h0);
    #1;
    checks++;
    if (bus.mst_ar_ready_o !== 4'b0001) begin
      errors++; $display("FAIL reset_pre_grant got=%b exp=0001", bus.mst_ar_ready_o);
    end
    @(negedge clk);
    bus.mst_ar_valid_i = '0;
    #1;
    checks++;
    if (bus.ccu_ar_valid_o !== 1'b1) begin
      errors++; $display("FAIL reset_issue got=%b exp=1", bus.ccu_ar_valid_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, bus.ccu_ar_valid_o, bus.ccu_ar_addr_o} !== {2'b00, 64'h0}) begin
      errors++; $display("FAIL reset_mid_issue got busy=%b v=%b addr=%h exp 0", busy, bus.ccu_ar_valid_o, bus.ccu_ar_addr_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({busy, bus.ccu_ar_valid_o} !== 2'b00) begin
      errors++; $display("FAIL reset_no_replay got busy=%b v=%b exp 00", busy, bus.ccu_ar_valid_o);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] e_ar  [3] = '{4'b0001, 4'b0000, 4'b1000};
    logic [3:0] e_aw  [3] = '{4'b0000, 4'b0010, 4'b0000};
    logic [5:0] e_id  [3] = '{6'h01, 6'h12, 6'h33};
    logic       e_wr  [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0] e_own [3] = '{2'd0, 2'd1, 2'd3};
    logic [6:0] got;
    bus.ccu_ar_ready_i = 1'b1; bus.ccu_aw_ready_i = 1'b1;
    bus.ccu_r_last_hs_i = 1'b1; bus.ccu_b_hs_i = 1'b1;
    @(negedge clk);
    set_ar(0, 64'hA0, 4'h1, 4'h0);
    set_aw(1, 64'hB1, 4'h2, 6'h00);
    set_ar(3, 64'hA3, 4'h3, 4'h0);
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if ({bus.mst_aw_ready_o, bus.mst_ar_ready_o} !== {e_aw[k%3], e_ar[k%3]}) begin
        errors++; $display("FAIL rr_grant_%0d got aw=%b ar=%b exp aw=%b ar=%b", k,
                           bus.mst_aw_ready_o, bus.mst_ar_ready_o, e_aw[k%3], e_ar[k%3]);
      end
      @(negedge clk);
      if (k == 5) begin
        bus.mst_ar_valid_i = '0; bus.mst_aw_valid_i = '0;
      end
      #1;
      got = e_wr[k%3] ? {bus.ccu_aw_valid_o, bus.ccu_aw_id_o} : {bus.ccu_ar_valid_o, bus.ccu_ar_id_o};
      checks++;
      if ({got, owner} !== {1'b1, e_id[k%3], e_own[k%3]}) begin
        errors++; $display("FAIL rr_issue_%0d got v_id=%h owner=%0d exp v_id=%h owner=%0d", k,
                           got, owner, {1'b1, e_id[k%3]}, e_own[k%3]);
      end
      @(negedge clk);
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_id_prefix();
    @(negedge clk);
    set_ar(2, 64'hABCD, 4'h5, 4'hA);
    #1;
    checks++;
    if (bus.mst_ar_ready_o !== 4'b0100) begin
      errors++; $display("FAIL idp_grant got=%b exp=0100", bus.mst_ar_ready_o);
    end
    @(negedge clk);
    bus.mst_ar_valid_i = '0;
    #1;
    checks++;
    if ({bus.ccu_ar_valid_o, bus.ccu_ar_id_o, bus.ccu_ar_addr_o, bus.ccu_ar_snoop_o, owner, busy}
        !== {1'b1, 6'b10_0101, 64'hABCD, 4'hA, 2'd2, 1'b1}) begin
      errors++; $display("FAIL idp_issue got v=%b id=%b addr=%h snoop=%h owner=%0d exp v=1 id=100101 addr=abcd snoop=a owner=2",
                         bus.ccu_ar_valid_o, bus.ccu_ar_id_o, bus.ccu_ar_addr_o, bus.ccu_ar_snoop_o, owner);
    end
    bus.ccu_ar_ready_i = 1'b1;
    @(negedge clk);
    bus.ccu_ar_ready_i = 1'b0;
    set_ar(0, 64'hC0, 4'h9, 4'h0);
    #1;
    checks++;
    if ({bus.ccu_ar_valid_o, busy, bus.mst_ar_ready_o} !== {1'b0, 1'b1, 4'b0000}) begin
      errors++; $display("FAIL idp_wait_r got v=%b busy=%b ready=%b exp v=0 busy=1 ready=0000",
                         bus.ccu_ar_valid_o, busy, bus.mst_ar_ready_o);
    end
    bus.ccu_r_last_hs_i = 1'b1;
    @(negedge clk);
    bus.ccu_r_last_hs_i = 1'b0;
    #1;
    checks++;
    if ({busy, bus.mst_ar_ready_o} !== {1'b0, 4'b0001}) begin
      errors++; $display("FAIL idp_regrant got busy=%b ready=%b exp busy=0 ready=0001", busy, bus.mst_ar_ready_o);
    end
    @(negedge clk);
    bus.mst_ar_valid_i = '0;
    #1;
    checks++;
    if ({bus.ccu_ar_valid_o, bus.ccu_ar_id_o} !== {1'b1, 6'h09}) begin
      errors++; $display("FAIL idp_second got v=%b id=%h exp v=1 id=09", bus.ccu_ar_valid_o, bus.ccu_ar_id_o);
    end
    drain();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_aw(1, 64'h1234_5678_9ABC_DEF0, 4'hC, 6'h00);
    #1;
    checks++;
    if (bus.mst_aw_ready_o !== 4'b0010) begin
      errors++; $display("FAIL bp_grant got=%b exp=0010", bus.mst_aw_ready_o);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.mst_aw_valid_i = '0;
      bus.ccu_aw_ready_i = 1'b0;
      bus.ccu_b_hs_i = (i == 0);
      bus.ccu_r_last_hs_i = (i == 1);
      #1;
      checks++;
      if ({bus.ccu_aw_valid_o, bus.ccu_aw_addr_o, bus.ccu_aw_id_o, bus.ccu_aw_atop_o}
          !== {1'b1, 64'h1234_5678_9ABC_DEF0, 6'h1C, 6'h00}) begin
        errors++; $display("FAIL bp_hold_%0d got v=%b addr=%h id=%h atop=%h exp v=1 addr=123456789abcdef0 id=1c atop=00",
                           i, bus.ccu_aw_valid_o, bus.ccu_aw_addr_o, bus.ccu_aw_id_o, bus.ccu_aw_atop_o);
      end
    end
    @(negedge clk);
    bus.ccu_b_hs_i = 1'b0; bus.ccu_r_last_hs_i = 1'b0;
    bus.ccu_aw_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.ccu_aw_valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_accept got=%b exp=1", bus.ccu_aw_valid_o);
    end
    @(negedge clk);
    bus.ccu_aw_ready_i = 1'b0;
    #1;
    checks++;
    if ({bus.ccu_aw_valid_o, busy} !== 2'b01) begin
      errors++; $display("FAIL bp_wait_b got v=%b busy=%b exp v=0 busy=1", bus.ccu_aw_valid_o, busy);
    end
    bus.ccu_b_hs_i = 1'b1;
    @(negedge clk);
    bus.ccu_b_hs_i = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL bp_done got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_atomic();
    @(negedge clk);
    set_aw(1, 64'h2000, 4'h7, 6'b100000);
    #1;
    checks++;
    if (bus.mst_aw_ready_o !== 4'b0010) begin
      errors++; $display("FAIL atomic_grant got=%b exp=0010", bus.mst_aw_ready_o);
    end
    @(negedge clk);
    bus.mst_aw_valid_i = '0;
    bus.ccu_aw_ready_i = 1'b1;
    #1;
    checks++;
    if ({bus.ccu_aw_valid_o, bus.ccu_aw_atop_o, bus.ccu_aw_id_o} !== {1'b1, 6'h20, 6'h17}) begin
      errors++; $display("FAIL atomic_issue got v=%b atop=%h id=%h exp v=1 atop=20 id=17",
                         bus.ccu_aw_valid_o, bus.ccu_aw_atop_o, bus.ccu_aw_id_o);
    end
    @(negedge clk);
    bus.ccu_aw_ready_i = 1'b0;
    bus.ccu_r_last_hs_i = 1'b1;
    #1;
    checks++;
    if ({busy, bus.ccu_aw_valid_o} !== 2'b10) begin
      errors++; $display("FAIL atomic_wait_b got busy=%b v=%b exp busy=1 v=0", busy, bus.ccu_aw_valid_o);
    end
    @(negedge clk);
    bus.ccu_r_last_hs_i = 1'b0;
    bus.ccu_b_hs_i = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL atomic_r_ignored_in_b got busy=%b exp=1", busy);
    end
    @(negedge clk);
    bus.ccu_b_hs_i = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL atomic_wait_r got busy=%b exp=1", busy);
    end
    @(negedge clk);
    bus.ccu_r_last_hs_i = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL atomic_hold got busy=%b exp=1", busy);
    end
    @(negedge clk);
    bus.ccu_r_last_hs_i = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL atomic_done got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_timeout();
    logic exp;
    @(negedge clk);
    set_aw(0, 64'h3000, 4'h1, 6'h00);
    bus.ccu_aw_ready_i = 1'b1;
    @(negedge clk);
    bus.mst_aw_valid_i = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      bus.ccu_aw_ready_i = 1'b0;
`ifdef CCU_ARB_TIMEOUT_EN
      exp = (n == 8);
`else
      exp = 1'b0;
`endif
      #1;
      checks++;
      if ({busy, timeout} !== {1'b1, exp}) begin
        errors++; $display("FAIL to_cycle_%0d got busy=%b timeout=%b exp busy=1 timeout=%b", n, busy, timeout, exp);
      end
    end
    bus.ccu_b_hs_i = 1'b1;
    @(negedge clk);
    bus.ccu_b_hs_i = 1'b0;
`ifdef CCU_ARB_TIMEOUT_EN
    exp = 1'b1;
`else
    exp = 1'b0;
`endif
    #1;
    checks++;
    if ({busy, timeout} !== {1'b0, exp}) begin
      errors++; $display("FAIL to_sticky got busy=%b timeout=%b exp busy=0 timeout=%b", busy, timeout, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_id_prefix();
    test_backpressure();
    test_atomic();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
